// File: rtl/vid_packetizer.sv
// Avalon-ST Video packetizer: turns a raw ready/valid pixel stream into an
// optional control packet (frame size) followed by a video data packet.
module vid_packetizer #(
  parameter int BPC       = 10,
  parameter int CHANNELS  = 3,
  parameter int W_BITS    = 12,
  parameter int H_BITS    = 12,
  parameter bit SEND_CTRL = 1'b1
) (
  input  logic                       pixel_clock,
  input  logic                       pixel_resetn,
  input  logic                       enable,
  input  logic [W_BITS-1:0]          cfg_width,
  input  logic [H_BITS-1:0]          cfg_height,
  input  logic [BPC*CHANNELS-1:0]    s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [BPC*CHANNELS-1:0]    m_data,
  output logic                       m_startofpacket,
  output logic                       m_endofpacket,
  output logic                       m_empty,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       frame_done,
  output logic [15:0]                frame_count
);

  localparam int DW = BPC * CHANNELS;
  // Control body carries 9 nibbles, CHANNELS of them per beat.
  localparam int NB = (9 + CHANNELS - 1) / CHANNELS;
  localparam logic [3:0] BEAT_LAST = 4'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    CTRL_HDR,
    CTRL_BODY,
    VID_HDR,
    VID_DATA
  } state_e;

  state_e             state_q, state_d, phase;
  logic [W_BITS-1:0]  w_q, w_d, x_q, x_d;
  logic [H_BITS-1:0]  h_q, h_d, y_q, y_d;
  logic [3:0]         beat_q, beat_d;
  logic               last_in_q, last_in_d;
  logic [DW-1:0]      m_data_q, m_data_d;
  logic               m_sop_q, m_sop_d;
  logic               m_eop_q, m_eop_d;
  logic               m_valid_q, m_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [15:0]        frame_count_q, frame_count_d;

  logic slot_free, s_rdy, start, eop_hs, x_last, y_last;

  function automatic logic [3:0] ctrl_nibble(input int idx, input logic [15:0] w,
                                             input logic [15:0] h);
    logic [3:0] n;
    case (idx)
      0:       n = w[15:12];
      1:       n = w[11:8];
      2:       n = w[7:4];
      3:       n = w[3:0];
      4:       n = h[15:12];
      5:       n = h[11:8];
      6:       n = h[7:4];
      7:       n = h[3:0];
      8:       n = 4'h3;
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  assign slot_free = !m_valid_q || m_ready;
  assign start     = enable && (cfg_width != '0) && (cfg_height != '0);
  // Once the last pixel is in the output register no further input is taken.
  assign s_rdy     = (state_q == VID_DATA) && slot_free && !last_in_q;
  assign eop_hs    = (state_q == VID_DATA) && last_in_q && m_valid_q && m_ready;
  assign x_last    = (x_q == w_q - 1'b1);
  assign y_last    = (y_q == h_q - 1'b1);

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d       = state_q;
    w_d           = w_q;
    h_d           = h_q;
    x_d           = x_q;
    y_d           = y_q;
    beat_d        = beat_q;
    last_in_d     = last_in_q;
    m_data_d      = m_data_q;
    m_sop_d       = m_sop_q;
    m_eop_d       = m_eop_q;
    m_valid_d     = m_valid_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    phase         = state_q;

    if (eop_hs) begin
      frame_done_d  = 1'b1;
      frame_count_d = frame_count_q + 16'd1;
      phase         = IDLE;
    end
    // Starting a frame falls straight into the header phase so the header
    // loads this cycle: no bubble after IDLE or between packets.
    if ((state_q == IDLE || eop_hs) && start) begin
      w_d   = cfg_width;
      h_d   = cfg_height;
      phase = SEND_CTRL ? CTRL_HDR : VID_HDR;
    end

    if (slot_free) m_valid_d = 1'b0;
    state_d = phase;

    case (phase)
      CTRL_HDR: begin
        if (slot_free) begin
          m_valid_d     = 1'b1;
          m_data_d      = '0;
          m_data_d[3:0] = 4'hF;
          m_sop_d       = 1'b1;
          m_eop_d       = 1'b0;
          beat_d        = '0;
          state_d       = CTRL_BODY;
        end
      end
      CTRL_BODY: begin
        if (slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = '0;
          for (int c = 0; c < CHANNELS; c++) begin
            m_data_d[c*BPC +: BPC] = BPC'(ctrl_nibble(int'(beat_q) * CHANNELS + c,
                                                      16'(w_q), 16'(h_q)));
          end
          m_sop_d = 1'b0;
          m_eop_d = (beat_q == BEAT_LAST);
          if (beat_q == BEAT_LAST) state_d = VID_HDR;
          else                     beat_d  = beat_q + 4'd1;
        end
      end
      VID_HDR: begin
        if (slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = '0;
          m_sop_d   = 1'b1;
          m_eop_d   = 1'b0;
          x_d       = '0;
          y_d       = '0;
          last_in_d = 1'b0;
          state_d   = VID_DATA;
        end
      end
      VID_DATA: begin
        if (s_valid && s_rdy) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          m_sop_d   = 1'b0;
          m_eop_d   = x_last && y_last;
          if (x_last) begin
            x_d = '0;
            if (y_last) last_in_d = 1'b1;
            else        y_d       = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pixel_clock or negedge pixel_resetn) begin
    if (!pixel_resetn) begin
      state_q       <= IDLE;
      w_q           <= '0;
      h_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      beat_q        <= '0;
      last_in_q     <= 1'b0;
      m_data_q      <= '0;
      m_sop_q       <= 1'b0;
      m_eop_q       <= 1'b0;
      m_valid_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q       <= state_d;
      w_q           <= w_d;
      h_q           <= h_d;
      x_q           <= x_d;
      y_q           <= y_d;
      beat_q        <= beat_d;
      last_in_q     <= last_in_d;
      m_data_q      <= m_data_d;
      m_sop_q       <= m_sop_d;
      m_eop_q       <= m_eop_d;
      m_valid_q     <= m_valid_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign s_ready         = s_rdy;
  assign m_data          = m_data_q;
  assign m_startofpacket = m_sop_q;
  assign m_endofpacket   = m_eop_q;
  assign m_empty         = 1'b0;
  assign m_valid         = m_valid_q;
  assign busy            = (state_q != IDLE);
  assign frame_done      = frame_done_q;
  assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_vid_packetizer.sv
// Scoreboard bench for vid_packetizer: two instances (with and without the
// control packet); expected beats are queued by stimulus, popped by a monitor.
module tb_vid_packetizer;

  localparam int BPC = 10;
  localparam int CH  = 3;
  localparam int DW  = BPC * CH;
  localparam int WB  = 12;
  localparam int HB  = 12;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          vend;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en   [2];
  logic [WB-1:0] cw   [2];
  logic [HB-1:0] ch   [2];
  logic [DW-1:0] sdat [2];
  logic          sval [2];
  logic          srdy [2];
  logic [DW-1:0] mdat [2];
  logic          msop [2];
  logic          meop [2];
  logic          memp [2];
  logic          mval [2];
  logic          mrdy [2];
  logic          busy [2];
  logic          fdone[2];
  logic [15:0]   fcnt [2];

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t exp0[$];
  beat_t exp1[$];
  bit    rand_bp = 1'b0;

  always #5 clk = ~clk;

  vid_packetizer #(.BPC(BPC), .CHANNELS(CH), .W_BITS(WB), .H_BITS(HB), .SEND_CTRL(1'b1)) dut (
    .pixel_clock(clk), .pixel_resetn(rst_n), .enable(en[0]),
    .cfg_width(cw[0]), .cfg_height(ch[0]),
    .s_data(sdat[0]), .s_valid(sval[0]), .s_ready(srdy[0]),
    .m_data(mdat[0]), .m_startofpacket(msop[0]), .m_endofpacket(meop[0]),
    .m_empty(memp[0]), .m_valid(mval[0]), .m_ready(mrdy[0]),
    .busy(busy[0]), .frame_done(fdone[0]), .frame_count(fcnt[0])
  );

  vid_packetizer #(.BPC(BPC), .CHANNELS(CH), .W_BITS(WB), .H_BITS(HB), .SEND_CTRL(1'b0)) dut_nc (
    .pixel_clock(clk), .pixel_resetn(rst_n), .enable(en[1]),
    .cfg_width(cw[1]), .cfg_height(ch[1]),
    .s_data(sdat[1]), .s_valid(sval[1]), .s_ready(srdy[1]),
    .m_data(mdat[1]), .m_startofpacket(msop[1]), .m_endofpacket(meop[1]),
    .m_empty(memp[1]), .m_valid(mval[1]), .m_ready(mrdy[1]),
    .busy(busy[1]), .frame_done(fdone[1]), .frame_count(fcnt[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic beat_t mk(input logic [DW-1:0] d, input logic s, input logic e,
                               input logic v);
    beat_t b;
    b.data = d;
    b.sop  = s;
    b.eop  = e;
    b.vend = v;
    return b;
  endfunction

  // Three 10-bit symbols, symbol 0 in the low bits.
  function automatic logic [DW-1:0] sym(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c);
    return {6'd0, c, 6'd0, b, 6'd0, a};
  endfunction

  function automatic logic [DW-1:0] pix(input int tag, input int i);
    return DW'(32'h0155_0000 + tag * 4096 + i * 273);
  endfunction

  task automatic push_exp(input int k, input beat_t b);
    if (k == 0) exp0.push_back(b);
    else        exp1.push_back(b);
  endtask

  // Control header, 3 body beats (W,H < 16), video header.
  task automatic push_ctrl_frame(input int k, input logic [3:0] w, input logic [3:0] h);
    push_exp(k, mk(sym(4'hF, 4'h0, 4'h0), 1'b1, 1'b0, 1'b0));
    push_exp(k, mk(sym(4'h0, 4'h0, 4'h0), 1'b0, 1'b0, 1'b0));
    push_exp(k, mk(sym(w,    4'h0, 4'h0), 1'b0, 1'b0, 1'b0));
    push_exp(k, mk(sym(4'h0, h,    4'h3), 1'b0, 1'b1, 1'b0));
    push_exp(k, mk('0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic pulse_enable(input int k);
    en[k] = 1'b1;
    @(posedge clk); #1;
    en[k] = 1'b0;
    check("hdr_latency_valid", 32'(mval[k]), 32'd1);
    check("hdr_latency_sop", 32'(msop[k]), 32'd1);
  endtask

  task automatic send_pixel(input int k, input logic [DW-1:0] d, input bit last);
    int n = 0;
    sdat[k] = d;
    sval[k] = 1'b1;
    @(negedge clk);
    while (!srdy[k] && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (!srdy[k]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL s_ready_timeout[%0d]: got s_ready 0, want 1", k);
    end else begin
      push_exp(k, mk(d, 1'b0, last, last));
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int k, input int tag, input int n);
    for (int i = 0; i < n; i++) send_pixel(k, pix(tag, i), (i == n - 1));
    sval[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    @(negedge clk);
    while (busy[k] && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (busy[k]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout[%0d]: got busy 1, want 0", k);
    end
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    beat_t held [2];
    bit    held_v [2];
    bit    fd_exp [2];
    beat_t e;
    bit    have;
    for (int k = 0; k < 2; k++) begin
      held_v[k] = 1'b0;
      fd_exp[k] = 1'b0;
      held[k]   = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          held_v[k] = 1'b0;
          fd_exp[k] = 1'b0;
        end else begin
          if (fd_exp[k] || fdone[k]) check("frame_done", 32'(fdone[k]), 32'(fd_exp[k]));
          fd_exp[k] = 1'b0;
          if (held_v[k]) begin
            check("stall_valid", 32'(mval[k]), 32'd1);
            check("stall_data", 32'(mdat[k]), 32'(held[k].data));
            check("stall_sop_eop", {30'd0, msop[k], meop[k]}, {30'd0, held[k].sop, held[k].eop});
          end
          if (mval[k] && mrdy[k]) begin
            have = 1'b0;
            if (k == 0 && exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
            if (k == 1 && exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
            if (!have) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_beat[%0d]: got data 0x%0h, want no beat", k, mdat[k]);
            end else begin
              check("beat_data", 32'(mdat[k]), 32'(e.data));
              check("beat_sop", 32'(msop[k]), 32'(e.sop));
              check("beat_eop", 32'(meop[k]), 32'(e.eop));
              check("beat_empty", 32'(memp[k]), 32'd0);
              fd_exp[k] = e.vend;
            end
          end
          held_v[k]    = mval[k] && !mrdy[k];
          held[k].data = mdat[k];
          held[k].sop  = msop[k];
          held[k].eop  = meop[k];
          held[k].vend = 1'b0;
        end
      end
    end
  end

  initial begin : backpressure
    forever begin
      @(posedge clk); #1;
      if (rand_bp) mrdy[0] = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; cw[k] = '0; ch[k] = '0;
      sdat[k] = '0; sval[k] = 1'b0; mrdy[k] = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_m_valid", 32'(mval[0]), 32'd0);
    check("rst_m_data", 32'(mdat[0]), 32'd0);
    check("rst_sop", 32'(msop[0]), 32'd0);
    check("rst_eop", 32'(meop[0]), 32'd0);
    check("rst_empty", 32'(memp[0]), 32'd0);
    check("rst_s_ready", 32'(srdy[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_frame_done", 32'(fdone[0]), 32'd0);
    check("rst_frame_count", 32'(fcnt[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // W=4, H=2, no backpressure, continuous pixels
    cw[0] = 12'd4; ch[0] = 12'd2;
    push_ctrl_frame(0, 4'd4, 4'd2);
    pulse_enable(0);
    check("busy_running", 32'(busy[0]), 32'd1);
    send_frame(0, 1, 8);
    wait_idle(0);
    check("frame_count_1", 32'(fcnt[0]), 32'd1);

    // W=3, H=3 under random backpressure
    cw[0] = 12'd3; ch[0] = 12'd3;
    push_ctrl_frame(0, 4'd3, 4'd3);
    rand_bp = 1'b1;
    pulse_enable(0);
    send_frame(0, 2, 9);
    wait_idle(0);
    rand_bp = 1'b0;
    mrdy[0] = 1'b1;
    check("frame_count_2", 32'(fcnt[0]), 32'd2);

    // No control packet, W=H=1: header with SOP only, pixel with EOP only
    cw[1] = 12'd1; ch[1] = 12'd1;
    push_exp(1, mk('0, 1'b1, 1'b0, 1'b0));
    pulse_enable(1);
    send_frame(1, 3, 1);
    wait_idle(1);
    check("nc_frame_count", 32'(fcnt[1]), 32'd1);

    // enable dropped at pixel 5, width change mid-frame ignored
    cw[0] = 12'd4; ch[0] = 12'd2;
    push_ctrl_frame(0, 4'd4, 4'd2);
    en[0] = 1'b1;
    @(posedge clk); #1;
    check("hdr_latency_held", 32'(mval[0]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        en[0] = 1'b0;
        cw[0] = 12'd2;
      end
      send_pixel(0, pix(4, i), (i == 7));
    end
    sval[0] = 1'b0;
    wait_idle(0);
    check("frame_count_3", 32'(fcnt[0]), 32'd3);
    repeat (4) @(posedge clk);
    #1;
    check("no_restart_busy", 32'(busy[0]), 32'd0);
    check("no_restart_valid", 32'(mval[0]), 32'd0);

    // new width takes effect at the next frame
    push_ctrl_frame(0, 4'd2, 4'd2);
    pulse_enable(0);
    send_frame(0, 5, 4);
    wait_idle(0);
    check("frame_count_4", 32'(fcnt[0]), 32'd4);

    // zero height keeps the block idle
    cw[0] = 12'd4; ch[0] = 12'd0;
    en[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("zero_h_valid", 32'(mval[0]), 32'd0);
    check("zero_h_busy", 32'(busy[0]), 32'd0);
    en[0] = 1'b0;

    // reset in the middle of the video data
    ch[0] = 12'd2;
    push_ctrl_frame(0, 4'd4, 4'd2);
    en[0] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_pixel(0, pix(6, i), 1'b0);
    #1;
    rst_n   = 1'b0;
    sval[0] = 1'b0;
    exp0.delete();
    #1;
    check("midrst_valid", 32'(mval[0]), 32'd0);
    check("midrst_data", 32'(mdat[0]), 32'd0);
    check("midrst_sop_eop", {30'd0, msop[0], meop[0]}, 32'd0);
    check("midrst_s_ready", 32'(srdy[0]), 32'd0);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_frame_count", 32'(fcnt[0]), 32'd0);
    @(posedge clk); #1;
    push_ctrl_frame(0, 4'd4, 4'd2);
    rst_n = 1'b1;
    check("post_rst_count", 32'(fcnt[0]), 32'd0);
    pulse_enable(0);
    send_frame(0, 7, 8);
    wait_idle(0);
    check("post_rst_frame_count", 32'(fcnt[0]), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", 32'(exp0.size()), 32'd0);
    check("q1_drained", 32'(exp1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
